// File: rtl/rob_mw_if.sv
// ---------------------------------------------------------------------------
// rob_mw_if -- bundle of every rob_mw signal except clock and reset.
//
// master modport (pipeline side) drives:
//   flush                          clear every entry this cycle
//   dispatch_valid / _T_new/_T_old per-lane allocation request and tags
//   cdb_valid / cdb_idx            per-lane completion by entry index
//   retire_en                      retire stage can accept this cycle
//   squash_valid / squash_idx      youngest surviving entry after mispredict
// slave modport (ROB side) drives:
//   dispatch_ready / dispatch_idx  allocation grant and slot per lane
//   retire_valid / _T_new / _T_old in-order retirement per lane
//   free_count / full / empty      occupancy status
// ---------------------------------------------------------------------------
interface rob_mw_if #(
  parameter int DEPTH     = 32,
  parameter int WIDTH     = 2,
  parameter int PREG_BITS = 6
);
  localparam int IDX = $clog2(DEPTH);

  logic                            flush;
  logic [WIDTH-1:0]                dispatch_valid;
  logic [WIDTH-1:0][PREG_BITS-1:0] dispatch_T_new;
  logic [WIDTH-1:0][PREG_BITS-1:0] dispatch_T_old;
  logic                            dispatch_ready;
  logic [WIDTH-1:0][IDX-1:0]       dispatch_idx;
  logic [WIDTH-1:0]                cdb_valid;
  logic [WIDTH-1:0][IDX-1:0]       cdb_idx;
  logic                            retire_en;
  logic [WIDTH-1:0]                retire_valid;
  logic [WIDTH-1:0][PREG_BITS-1:0] retire_T_new;
  logic [WIDTH-1:0][PREG_BITS-1:0] retire_T_old;
  logic                            squash_valid;
  logic [IDX-1:0]                  squash_idx;
  logic [IDX:0]                    free_count;
  logic                            full;
  logic                            empty;

  modport master (
    output flush, dispatch_valid, dispatch_T_new, dispatch_T_old,
           cdb_valid, cdb_idx, retire_en, squash_valid, squash_idx,
    input  dispatch_ready, dispatch_idx, retire_valid, retire_T_new,
           retire_T_old, free_count, full, empty
  );

  modport slave (
    input  flush, dispatch_valid, dispatch_T_new, dispatch_T_old,
           cdb_valid, cdb_idx, retire_en, squash_valid, squash_idx,
    output dispatch_ready, dispatch_idx, retire_valid, retire_T_new,
           retire_T_old, free_count, full, empty
  );
endinterface

// File: rtl/rob_mw.sv
// ---------------------------------------------------------------------------
// rob_mw -- multi-wide reorder buffer (circular, head = oldest, tail = next
// free slot). Each cycle it can allocate, complete and retire up to WIDTH
// entries, squash everything younger than a surviving branch, or flush all.
//
// Ports:
//   clock  sole clock, all state on posedge
//   reset  asynchronous active-high, clears every entry immediately
//   bus    rob_mw_if.slave, see rob_mw_if.sv for the signal list
// ---------------------------------------------------------------------------
module rob_mw #(
  parameter int DEPTH     = 32,
  parameter int WIDTH     = 2,
  parameter int PREG_BITS = 6
) (
  input logic     clock,
  input logic     reset,
  rob_mw_if.slave bus
);
  localparam int IDX = $clog2(DEPTH);
  localparam int CNT = IDX + 1;

  logic [DEPTH-1:0]     busy_q, busy_d;
  logic [DEPTH-1:0]     done_q, done_d;
  logic [PREG_BITS-1:0] tnew_q [DEPTH];
  logic [PREG_BITS-1:0] tnew_d [DEPTH];
  logic [PREG_BITS-1:0] told_q [DEPTH];
  logic [PREG_BITS-1:0] told_d [DEPTH];
  logic [IDX-1:0]       head_q, head_d;
  logic [IDX-1:0]       tail_q, tail_d;
  logic [CNT-1:0]       count_q, count_d;

  logic [CNT-1:0]       freeCount;
  logic [CNT-1:0]       dispCount;
  logic [CNT-1:0]       retireCount;
  logic [WIDTH-1:0]     retireValid;
  logic                 squashHit;
  logic [IDX-1:0]       sqOff;

  // Status is derived from the registered occupancy only, so a slot freed by
  // retirement this cycle is not offered to dispatch until the next cycle.
  assign freeCount          = CNT'(DEPTH) - count_q;
  assign bus.free_count     = freeCount;
  assign bus.full           = (count_q == CNT'(DEPTH));
  assign bus.empty          = (count_q == '0);
  assign bus.dispatch_ready = (freeCount >= CNT'(WIDTH)) && !bus.squash_valid
                              && !bus.flush;
  assign bus.retire_valid   = retireValid;

  // Valid lanes pack onto consecutive slots from tail; invalid lanes get 0.
  always_comb begin
    dispCount        = '0;
    bus.dispatch_idx = '0;
    for (int k = 0; k < WIDTH; k++) begin
      if (bus.dispatch_valid[k]) begin
        bus.dispatch_idx[k] = tail_q + IDX'(dispCount);
        dispCount           = dispCount + CNT'(1);
      end
    end
  end

  // Lane k retires only if every entry from head up to head+k is done, so the
  // lanes form an unbroken prefix and retireCount doubles as the head step.
  always_comb begin
    logic           chain;
    logic [IDX-1:0] slot;
    chain            = bus.retire_en;
    retireCount      = '0;
    retireValid      = '0;
    bus.retire_T_new = '0;
    bus.retire_T_old = '0;
    for (int k = 0; k < WIDTH; k++) begin
      slot  = head_q + IDX'(k);
      chain = chain && busy_q[slot] && done_q[slot];
      if (chain) begin
        retireValid[k]      = 1'b1;
        bus.retire_T_new[k] = tnew_q[slot];
        bus.retire_T_old[k] = told_q[slot];
        retireCount         = retireCount + CNT'(1);
      end
    end
  end

  // Updates are layered completion -> retire -> squash so that a clear always
  // wins over a same-cycle done mark on the same entry.
  always_comb begin
    logic [IDX-1:0] slot;
    logic [IDX-1:0] entOff;
    busy_d    = busy_q;
    done_d    = done_q;
    tnew_d    = tnew_q;
    told_d    = told_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    slot      = '0;
    entOff    = '0;
    squashHit = bus.squash_valid && busy_q[bus.squash_idx];
    sqOff     = bus.squash_idx - head_q;

    if (bus.flush) begin
      busy_d  = '0;
      done_d  = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      for (int k = 0; k < WIDTH; k++) begin
        if (bus.cdb_valid[k] && busy_q[bus.cdb_idx[k]]) begin
          done_d[bus.cdb_idx[k]] = 1'b1;
        end
      end

      for (int k = 0; k < WIDTH; k++) begin
        if (retireValid[k]) begin
          slot         = head_q + IDX'(k);
          busy_d[slot] = 1'b0;
          done_d[slot] = 1'b0;
        end
      end
      head_d = head_q + IDX'(retireCount);

      if (squashHit) begin
        // Age is the distance from head; anything older-than-tail but younger
        // than the squash point is dropped.
        for (int i = 0; i < DEPTH; i++) begin
          entOff = IDX'(i) - head_q;
          if (busy_q[i] && (entOff > sqOff)) begin
            busy_d[i] = 1'b0;
            done_d[i] = 1'b0;
          end
        end
        // If the squash point itself retires, nothing survives and the
        // buffer collapses onto the new head.
        if (CNT'(sqOff) < retireCount) begin
          tail_d  = head_d;
          count_d = '0;
        end else begin
          tail_d  = bus.squash_idx + IDX'(1);
          count_d = CNT'(sqOff) + CNT'(1) - retireCount;
        end
      end else if (bus.dispatch_ready) begin
        for (int k = 0; k < WIDTH; k++) begin
          if (bus.dispatch_valid[k]) begin
            slot         = bus.dispatch_idx[k];
            busy_d[slot] = 1'b1;
            done_d[slot] = 1'b0;
            tnew_d[slot] = bus.dispatch_T_new[k];
            told_d[slot] = bus.dispatch_T_old[k];
          end
        end
        tail_d  = tail_q + IDX'(dispCount);
        count_d = count_q - retireCount + dispCount;
      end else begin
        count_d = count_q - retireCount;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy_q  <= '0;
      done_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        tnew_q[i] <= '0;
        told_q[i] <= '0;
      end
    end else begin
      busy_q  <= busy_d;
      done_q  <= done_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        tnew_q[i] <= tnew_d[i];
        told_q[i] <= told_d[i];
      end
    end
  end
endmodule

// File: doc/rob_mw.md
ROB_MW -- requirements
Module: rob_mw

Interface
REQ-001 Parameter DEPTH, default 32, entry count; power of two, 4..64.
REQ-002 Parameter WIDTH, default 2, dispatch/complete/retire lanes per cycle; 1..4, WIDTH <= DEPTH/2.
REQ-003 Parameter PREG_BITS, default 6, physical register tag width.
REQ-004 clock  input  1  sole clock; all state updates on posedge.
REQ-005 reset  input  1  asynchronous, active-high.
REQ-006 flush  input  1  synchronous clear of all entries (mispredict at retire / exception).
REQ-007 dispatch_valid  input  WIDTH  per-lane dispatch request.
REQ-008 dispatch_T_new, dispatch_T_old  input  WIDTH x PREG_BITS  new/old physical tags per lane.
REQ-009 dispatch_ready  output  1  high when free_count >= WIDTH and no squash/flush this cycle.
REQ-010 dispatch_idx  output  WIDTH x log2(DEPTH)  entry index each valid lane receives this cycle.
REQ-011 cdb_valid  input  WIDTH; cdb_idx  input  WIDTH x log2(DEPTH)  completion by entry index.
REQ-012 retire_en  input  1  retire stage may accept this cycle.
REQ-013 retire_valid  output  WIDTH; retire_T_new, retire_T_old  output  WIDTH x PREG_BITS.
REQ-014 squash_valid  input  1; squash_idx  input  log2(DEPTH)  youngest surviving entry after branch mispredict.
REQ-015 free_count  output  log2(DEPTH)+1  free entries (registered); full, empty  output  1.

Function
REQ-016 Circular buffer: head = oldest entry, tail = next free slot, count = occupancy; indices wrap modulo DEPTH.
REQ-017 Dispatch accepted only when dispatch_ready; valid lanes allocate consecutive slots from tail in lane-order, invalid lanes skipped (no hole); tail and count advance by popcount(dispatch_valid).
REQ-018 dispatch_valid while dispatch_ready low: no allocation, no state change.
REQ-019 dispatch_idx combinational from tail and dispatch_valid; undefined lanes output 0.
REQ-020 New entry: busy=1, done=0, T_new/T_old stored.
REQ-021 Completion: cdb lane with valid and busy target sets done next cycle; cdb to non-busy entry ignored; duplicate indices across lanes harmless.
REQ-022 Retire combinational from registered state: lane k valid iff entries head..head+k all busy and done and retire_en; retire_T_new/T_old from those entries; invalid lanes output 0 tags.
REQ-023 On posedge, retired entries cleared busy, head and count move by retired lane count.
REQ-024 Completion and retire same entry same cycle: not retired that cycle (done visible next cycle; 1-cycle complete-to-retire latency minimum).
REQ-025 Squash: entries strictly younger than squash_idx (squash_idx+1 .. tail-1) cleared; tail := squash_idx+1 mod DEPTH; count recomputed.
REQ-026 squash_idx not busy: squash ignored.
REQ-027 Squash with retire same cycle: retire proceeds; squash applied to remaining; if squash_idx itself retires, surviving set = entries older than tail after retire only.
REQ-028 Completion targeting a squashed entry same cycle: ignored.
REQ-029 flush priority over squash, dispatch, completion, retire: all busy/done cleared, head=tail=0, count=0; retire outputs still reflect current state this cycle but nothing retires.
REQ-030 free_count = DEPTH - count; full = (count==DEPTH); empty = (count==0); dispatch/retire same cycle: free_count uses pre-retire count (freed slots usable next cycle).
REQ-031 All counters sized log2(DEPTH)+1; no overflow since dispatch requires free_count >= WIDTH.

Reset
REQ-032 reset asserted: immediately, independent of clock, all busy/done=0, stored tags=0, head=tail=0, count=0.
REQ-033 During reset: free_count=DEPTH, full=0, empty=1, dispatch_ready=1 after release, retire_valid=0.
REQ-034 Reset mid-operation discards all entries; first post-reset dispatch gets index 0.

Verification (DEPTH=8, WIDTH=2, PREG_BITS=6)
REQ-035 Reset, dispatch lanes (T_new 10,11) -> dispatch_idx 0,1; free_count 6 next cycle; complete 0,1; retire_en -> retire_valid=11 one cycle later with T_new 10,11; empty=1 after.
REQ-036 Dispatch 4 cycles x2 -> full=1, dispatch_ready=0; further dispatch ignored; retire 2 -> free_count 2 following cycle; next dispatch idx 0,1 wrap correctly.
REQ-037 Entries 0..5 busy, complete 1 only -> retire_valid=00; complete 0 -> retire_valid=11 (entries 0,1) next cycle.
REQ-038 Entries 2..7 busy, squash_idx=4 -> entries 5..7 cleared, tail=5, free_count 5; squash_idx pointing at free entry -> no change.
REQ-039 Squash_idx=3 with retire of 2 and dispatch request same cycle -> entry 2 retires, dispatch ignored, tail=4, count=1.
REQ-040 Reset asserted asynchronously between edges with 6 entries -> outputs at reset values before next edge; flush with 4 entries -> empty next cycle, no retire.
